bus_matrix_rr: RTL
==================

// Module: bus_matrix_rr
// PURPOSE
//  Shared system bus for NUM_M masters and NUM_S slaves, with round-robin master arbitration.
//  Address windows per slave are set by parameters. Transfers are one at a time:
//  one owner and at most one selected slave. Read latency is parametrised.
//  Bus errors are reported on decode miss. Sits between cores/DMA and the memory/peripheral slaves.
// PARAMETERS
//  NUM_M   2                        number of masters (>=1)
//  NUM_S   2                        number of slaves (>=1)
//  AW      16                       address width
//  DW      64                       data width
//  RD_LAT  2                        XFER cycles for a read (>=1); writes always take 1
//  S_BASE  {16'h7000,16'h0000}      packed NUM_S*AW, slave i base at [i*AW+:AW]
//  S_LAST  {16'h71FF,16'h07FF}      packed NUM_S*AW, slave i inclusive last address
// PORTS
//  clk      in   1         clock, rising edge
//  reset_n  in   1         asynchronous reset, active low
//  m_req    in   NUM_M     per-master request; held high until m_done
//  m_wr     in   NUM_M     per-master write(1)/read(0)
//  m_addr   in   NUM_M*AW  per-master address
//  m_dout   in   NUM_M*DW  per-master write data
//  m_grant  out  NUM_M     one-hot grant, registered
//  m_din    out  DW        read data to owner (shared)
//  m_done   out  1         one-cycle pulse: transfer complete (m_din valid when read)
//  m_err    out  1         one-cycle pulse with m_done: decode miss
//  s_sel    out  NUM_S     one-hot slave select, registered
//  s_addr   out  AW        owner address
//  s_wr     out  1         owner write strobe
//  s_din    out  DW        owner write data
//  s_dout   in   NUM_S*DW  per-slave read data
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE, ptr=0; m_grant, s_sel, m_done, m_err = 0.
//   - Reset mid-transfer abandons the transfer immediately.
//  FSM states: IDLE, GRANT, XFER.
//  IDLE:
//   - If any m_req, choose the first requesting index starting at ptr, wrapping modulo NUM_M.
//   - Latch owner; -> GRANT.
//  GRANT:
//   - m_grant[owner]=1.
//   - Decode m_addr[owner] against the windows (base<=addr<=last); lowest slave index wins on overlap.
//   - Register s_sel; cnt=0; -> XFER.
//  XFER:
//   - cnt increments each cycle.
//   - Write: complete on the first XFER cycle.
//   - Read: complete when cnt==RD_LAT-1.
//   - On completion: m_done=1 for that cycle; next state IDLE.
//   - Next-cycle register values: grant=0, s_sel=0, ptr=(owner+1)%NUM_M (modulo wrap).
//  Latency (request seen at cycle 0 in IDLE):
//   - Grant at cycle 1; s_sel at cycle 2.
//   - Write done at cycle 2; read done at cycle 1+RD_LAT.
//  Decode miss:
//   - s_sel stays 0; m_din=0.
//   - m_done=1 and m_err=1 on the first XFER cycle, read or write.
//  Abort: if m_req[owner] drops in GRANT/XFER -> IDLE next cycle, no m_done, grant/sel cleared, ptr advances.
//  Fairness:
//   - IDLE lasts at least 1 cycle between transfers.
//   - With all masters requesting, grants rotate 0,1,..,NUM_M-1,0.
//  Simultaneous requests: only the winner sees grant; losers keep m_req high, no other effect.
//  Datapath (combinational):
//   - s_addr/s_wr/s_din = owner's inputs while state!=IDLE, else 0.
//   - m_din = s_dout of the selected slave, else 0.
//  Width rules: owner and ptr are clog2(NUM_M) wide (min 1); cnt is clog2(RD_LAT+1) wide.
// STRUCTURE
//  Package bus_pkg:
//   - state encoding (IDLE=2'b00, GRANT=2'b01, XFER=2'b10).
//   - default address-map constants.
//   - function addr_hit(addr,base,last).
//  Sub-module rr_arbiter (NUM_M): inputs req, ptr; outputs one-hot gnt and encoded idx.
//   - Combinational.
//   - Instantiated once.
//  Top: FSM, ptr/owner/cnt registers, decoder, muxes.
// TESTING
//  1. Read, M0 only: m_req=01, addr 16'h0010, s_dout0=64'hA5A5_0000_0000_0001, RD_LAT=2 ->
//     grant=01 @1, s_sel=01 @2, m_done @3 with m_din=A5A5_0000_0000_0001.
//  2. Write, M1: addr 16'h7100, m_dout=64'hDEAD_BEEF ->
//     s_sel=10, s_wr=1, s_din=DEAD_BEEF, m_done @2, m_err=0.
//  3. Both masters held requesting for 4 transfers -> grant order M0,M1,M0,M1; >=1 IDLE cycle between.
//  4. Decode miss addr 16'h3000 ->
//     s_sel=00, m_din=0, m_done=m_err=1 @2; ptr advances.
//  5. Abort: M0 read, drop m_req in first XFER cycle ->
//     no m_done, grant=0 next cycle, pending M1 granted next.
//  6. reset_n low mid-read (XFER) ->
//     m_grant, s_sel, m_done = 0 immediately; after release, M0 wins (ptr=0).

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus matrix: FSM encoding, default address map,
// and the address-window hit test used by the slave decoder.
// No logic of its own; no latency or backpressure.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    XFER  = 2'b10
  } state_t;

  // Widest address the hit helper handles; callers zero-extend into it.
  localparam int MAX_AW = 64;

  // Two-slave default map: slave 0 = 0x0000..0x07FF, slave 1 = 0x7000..0x71FF.
  localparam logic [31:0] DEF_S_BASE = {16'h7000, 16'h0000};
  localparam logic [31:0] DEF_S_LAST = {16'h71FF, 16'h07FF};

  // Inclusive window test: base <= addr <= last.
  function automatic logic addr_hit(
    input logic [MAX_AW-1:0] addr,
    input logic [MAX_AW-1:0] base,
    input logic [MAX_AW-1:0] last
  );
    return (addr >= base) && (addr <= last);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo NUM_M.
// Latency: combinational.  Backpressure: none; the caller decides when to act on the pick.
// Ports: req (requests), ptr (search start) -> gnt (one-hot winner), idx (encoded winner).
module rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [NUM_M-1:0] gnt,
  output logic [IW-1:0]    idx
);

  function automatic int slot(input logic [IW-1:0] p, input int ofs);
    return (int'(p) + ofs) % NUM_M;
  endfunction

  always_comb begin
    gnt = '0;
    idx = '0;
    // Scan from the farthest slot back towards ptr so the nearest requester is written last.
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if ((req & (NUM_M'(1) << slot(ptr, i))) != '0) begin
        gnt = NUM_M'(1) << slot(ptr, i);
        idx = IW'(slot(ptr, i));
      end
    end
  end

endmodule

// File: rtl/bus_matrix_rr.sv
// Shared NUM_M x NUM_S bus: round-robin master arbitration, window decode, one transfer at a time.
// Latency from request seen in IDLE: grant +1, slave select +2, write/miss done +2, read done +1+RD_LAT.
// Backpressure: losing masters simply hold m_req; dropping the owner's m_req aborts the transfer.
// Ports: clk, reset_n; master side m_req/m_wr/m_addr/m_dout in, m_grant/m_din/m_done/m_err out;
//        slave side s_sel/s_addr/s_wr/s_din out, s_dout in (packed per slave).
module bus_matrix_rr
  import bus_pkg::*;
#(
  parameter int                  NUM_M  = 2,
  parameter int                  NUM_S  = 2,
  parameter int                  AW     = 16,
  parameter int                  DW     = 64,
  parameter int                  RD_LAT = 2,
  parameter logic [NUM_S*AW-1:0] S_BASE = DEF_S_BASE,
  parameter logic [NUM_S*AW-1:0] S_LAST = DEF_S_LAST
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_wr,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_dout,
  output logic [NUM_M-1:0]    m_grant,
  output logic [DW-1:0]       m_din,
  output logic                m_done,
  output logic                m_err,
  output logic [NUM_S-1:0]    s_sel,
  output logic [AW-1:0]       s_addr,
  output logic                s_wr,
  output logic [DW-1:0]       s_din,
  input  logic [NUM_S*DW-1:0] s_dout
);

  localparam int OW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = $clog2(RD_LAT + 1);

  state_t           state;
  state_t           state_nxt;
  logic [OW-1:0]    ptr;
  logic [OW-1:0]    ptr_nxt;
  logic [OW-1:0]    owner;
  logic [CW-1:0]    cnt;
  logic [NUM_M-1:0] arb_gnt;
  logic [OW-1:0]    arb_idx;
  logic [NUM_S-1:0] dec_sel;
  logic             owner_req;
  logic             owner_wr;
  logic [AW-1:0]    owner_addr;
  logic [DW-1:0]    owner_dout;
  logic             miss;
  logic             xfer_last;

  rr_arbiter #(.NUM_M(NUM_M), .IW(OW)) u_arb (
    .req (m_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign owner_req  = m_req[owner];
  assign owner_wr   = m_wr[owner];
  assign owner_addr = m_addr[int'(owner)*AW +: AW];
  assign owner_dout = m_dout[int'(owner)*DW +: DW];
  assign ptr_nxt    = (owner == OW'(NUM_M - 1)) ? '0 : owner + OW'(1);

  // A cleared select while transferring can only come from a decode miss.
  assign miss      = (s_sel == '0);
  assign xfer_last = miss | owner_wr | (cnt == CW'(RD_LAT - 1));

  // Lowest slave index wins on overlapping windows: it is assigned last.
  always_comb begin
    dec_sel = '0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if (addr_hit(MAX_AW'(owner_addr), MAX_AW'(S_BASE[i*AW +: AW]), MAX_AW'(S_LAST[i*AW +: AW]))) begin
        dec_sel = NUM_S'(1) << i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m_done    = 1'b0;
    m_err     = 1'b0;
    case (state)
      IDLE: begin
        if (|m_req) state_nxt = GRANT;
      end
      GRANT: begin
        state_nxt = owner_req ? XFER : IDLE;
      end
      XFER: begin
        // Abort takes priority: no completion is reported once the owner lets go.
        if (!owner_req) begin
          state_nxt = IDLE;
        end else if (xfer_last) begin
          state_nxt = IDLE;
          m_done    = 1'b1;
          m_err     = miss;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      m_grant <= '0;
      s_sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_req) begin
            owner   <= arb_idx;
            m_grant <= arb_gnt;
          end
        end
        GRANT: begin
          if (owner_req) begin
            s_sel <= dec_sel;
            cnt   <= '0;
          end else begin
            m_grant <= '0;
            ptr     <= ptr_nxt;
          end
        end
        XFER: begin
          if (state_nxt == IDLE) begin
            m_grant <= '0;
            s_sel   <= '0;
            ptr     <= ptr_nxt;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Owner's request is presented to the slaves for the whole GRANT/XFER span.
  assign s_addr = (state != IDLE) ? owner_addr : '0;
  assign s_wr   = (state != IDLE) ? owner_wr   : 1'b0;
  assign s_din  = (state != IDLE) ? owner_dout : '0;

  always_comb begin
    m_din = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (s_sel[i]) m_din = s_dout[i*DW +: DW];
    end
  end

endmodule
